// File: rtl/puf_scan_pkg.sv
// Shared constants and scan state encoding for the PUF response scanner.
package puf_scan_pkg;

  localparam int NUM_CH    = 16;
  localparam int SEL_W     = 4;
  localparam int SET_CNT_W = 8;
  localparam int SMP_CNT_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    VOTE,
    DONE
  } scan_state_t;

endpackage

// File: rtl/puf_maj_vote.sv
// Ones-counter over one channel's sample window, with the voted bit and an
// all-samples-agree flag available combinationally during the vote cycle.
module puf_maj_vote
  import puf_scan_pkg::*;
#(
  parameter int SAMPLES = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  input  logic i_bit,
  output logic o_bit,
  output logic o_stable
);

  localparam logic [SMP_CNT_W-1:0] HALF = SMP_CNT_W'(SAMPLES / 2);
  localparam logic [SMP_CNT_W-1:0] ALL  = SMP_CNT_W'(SAMPLES);

  logic [SMP_CNT_W-1:0] r_ones;

  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_ones <= '0;
    end else if (i_en && i_bit) begin
      r_ones <= r_ones + 1'b1;
    end
  end

  assign o_bit    = (r_ones > HALF);
  assign o_stable = (r_ones == '0) || (r_ones == ALL);

endmodule

// File: rtl/puf_resp_scanner.sv
// Sweeps the 16:1 PUF response mux, majority-votes each channel and holds the
// 16-bit result on resp_valid until resp_ready (scan cost 16*(SETTLE+SAMPLES+1)).
module puf_resp_scanner
  import puf_scan_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int SAMPLES       = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              mux_out,
  output logic [SEL_W-1:0]  se,
  output logic              busy,
  output logic [NUM_CH-1:0] resp,
  output logic [NUM_CH-1:0] resp_stable,
  output logic              resp_valid,
  input  logic              resp_ready
);

  localparam logic [SET_CNT_W-1:0] SET_LAST = SET_CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [SMP_CNT_W-1:0] SMP_LAST = SMP_CNT_W'(SAMPLES - 1);
  localparam logic [SEL_W-1:0]     CH_LAST  = SEL_W'(NUM_CH - 1);

  scan_state_t           r_state;
  logic [SEL_W-1:0]      r_se;
  logic                  r_busy;
  logic [NUM_CH-1:0]     r_resp;
  logic [NUM_CH-1:0]     r_stable;
  logic                  r_valid;
  logic [SET_CNT_W-1:0]  r_set_cnt;
  logic [SMP_CNT_W-1:0]  r_smp_cnt;

  logic w_smp_en;
  logic w_clr;
  logic w_bit;
  logic w_stable;

  // The ones counter only accumulates inside SAMPLE; it still holds its total
  // through the VOTE cycle and is cleared on the edge that leaves it.
  assign w_smp_en = (r_state == SAMPLE);
  assign w_clr    = (r_state != SAMPLE) || abort;

  puf_maj_vote #(
    .SAMPLES (SAMPLES)
  ) u_vote (
    .clk      (clk),
    .reset    (reset),
    .i_clr    (w_clr),
    .i_en     (w_smp_en),
    .i_bit    (mux_out),
    .o_bit    (w_bit),
    .o_stable (w_stable)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_se      <= '0;
      r_busy    <= 1'b0;
      r_resp    <= '0;
      r_stable  <= '0;
      r_valid   <= 1'b0;
      r_set_cnt <= '0;
      r_smp_cnt <= '0;
    end else if (abort && (r_state != IDLE)) begin
      // Partial resp bits are kept but never flagged valid.
      r_state   <= IDLE;
      r_se      <= '0;
      r_busy    <= 1'b0;
      r_valid   <= 1'b0;
      r_set_cnt <= '0;
      r_smp_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start && !abort) begin
            r_state   <= SETTLE;
            r_busy    <= 1'b1;
            r_se      <= '0;
            r_resp    <= '0;
            r_stable  <= '0;
            r_set_cnt <= '0;
            r_smp_cnt <= '0;
          end
        end
        SETTLE: begin
          if (r_set_cnt == SET_LAST) begin
            r_set_cnt <= '0;
            r_state   <= SAMPLE;
          end else begin
            r_set_cnt <= r_set_cnt + 1'b1;
          end
        end
        SAMPLE: begin
          if (r_smp_cnt == SMP_LAST) begin
            r_smp_cnt <= '0;
            r_state   <= VOTE;
          end else begin
            r_smp_cnt <= r_smp_cnt + 1'b1;
          end
        end
        VOTE: begin
          r_resp[r_se]   <= w_bit;
          r_stable[r_se] <= w_stable;
          if (r_se == CH_LAST) begin
            r_state <= DONE;
            r_valid <= 1'b1;
          end else begin
            r_se    <= r_se + 1'b1;
            r_state <= SETTLE;
          end
        end
        DONE: begin
          if (resp_ready) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign se          = r_se;
  assign busy        = r_busy;
  assign resp        = r_resp;
  assign resp_stable = r_stable;
  assign resp_valid  = r_valid;

endmodule

// File: tb/tb_puf_resp_scanner.sv
// Bench for puf_resp_scanner: default instance plus a SETTLE=1/SAMPLES=1 instance.
module tb_puf_resp_scanner;

  localparam int S = 4;
  localparam int N = 5;
  localparam int P = S + N + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, abort, resp_ready;
  logic        mux_out = 1'b0;
  logic [3:0]  se;
  logic        busy, resp_valid;
  logic [15:0] resp, resp_stable;

  logic        start2, ready2, mux2, busy2, valid2;
  logic        abort2 = 1'b0;
  logic [3:0]  se2;
  logic [15:0] resp2, stable2;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int kedge    = 1 << 30;
  int mux_mode = 0;
  logic [15:0] pat  = 16'h0;
  logic [15:0] pat2 = 16'h0;
  logic [15:0] smp_tbl [16];

  puf_resp_scanner #(.SETTLE_CYCLES(S), .SAMPLES(N)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .mux_out(mux_out),
    .se(se), .busy(busy), .resp(resp), .resp_stable(resp_stable),
    .resp_valid(resp_valid), .resp_ready(resp_ready)
  );

  puf_resp_scanner #(.SETTLE_CYCLES(1), .SAMPLES(1)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .abort(abort2), .mux_out(mux2),
    .se(se2), .busy(busy2), .resp(resp2), .resp_stable(stable2),
    .resp_valid(valid2), .resp_ready(ready2)
  );

  assign mux2 = pat2[se2];

  always @(posedge clk) cyc <= cyc + 1;

  // Mux model: mode 0 returns bit se of pat; mode 1 replays smp_tbl[ch][j] in
  // the j-th sample slot of each channel window and noise everywhere else.
  always @(posedge clk) begin : mux_drv
    int d, ch, pos;
    #1;
    d   = cyc - kedge;
    ch  = (d >= 0) ? d / P : 99;
    pos = (d >= 0) ? d % P : 0;
    if (mux_mode == 0) mux_out = pat[se];
    else if (d >= 0 && ch < 16 && pos >= S && pos < S + N) mux_out = smp_tbl[ch][pos - S];
    else mux_out = 1'($urandom_range(0, 1));
  end

  function automatic void model_scan(output logic [15:0] r, output logic [15:0] s);
    for (int c = 0; c < 16; c++) begin
      int ones;
      ones = 0;
      for (int j = 0; j < N; j++) ones += int'(smp_tbl[c][j]);
      r[c] = (2 * ones > N);
      s[c] = (ones == 0) || (ones == N);
    end
  endfunction

  task automatic rand_tbl();
    for (int c = 0; c < 16; c++) begin
      case ($urandom_range(0, 2))
        0:       smp_tbl[c] = 16'h0000;
        1:       smp_tbl[c] = 16'hFFFF;
        default: smp_tbl[c] = 16'($urandom);
      endcase
    end
  endtask

  task automatic start_and_wait(output int lat, output int se_err);
    lat = -1;
    se_err = 0;
    start = 1'b1;
    kedge = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    for (int d = 0; d < 400; d++) begin
      if (resp_valid === 1'b1) begin
        lat = d;
        break;
      end
      if (se !== 4'(d / P)) se_err++;
      @(negedge clk);
    end
  endtask

  task automatic ack();
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL por_busy: got %b want 0", busy); end
    n_checks++; if (se !== 4'h0) begin n_fail++; $display("FAIL por_se: got %h want 0", se); end
    n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL por_valid: got %b want 0", resp_valid); end
    n_checks++; if (resp !== 16'h0) begin n_fail++; $display("FAIL por_resp: got %h want 0", resp); end
    n_checks++; if (resp_stable !== 16'h0) begin n_fail++; $display("FAIL por_stable: got %h want 0", resp_stable); end
    mux_mode = 0;
    pat = 16'hA5C3;
    start = 1'b1;
    kedge = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    repeat (65) @(negedge clk);
    n_checks++; if (se !== 4'd6) begin n_fail++; $display("FAIL mid_se: got %h want 6", se); end
    n_checks++; if (resp !== (pat & 16'h003F)) begin n_fail++; $display("FAIL mid_resp: got %h want %h", resp, pat & 16'h003F); end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++; if (se !== 4'h0) begin n_fail++; $display("FAIL rst_se: got %h want 0", se); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_checks++; if (resp !== 16'h0) begin n_fail++; $display("FAIL rst_resp: got %h want 0", resp); end
    n_checks++; if (resp_stable !== 16'h0) begin n_fail++; $display("FAIL rst_stable: got %h want 0", resp_stable); end
    n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", resp_valid); end
    repeat (20) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_stays_idle: got %b want 0", busy); end
  endtask

  task automatic test_clean_scan();
    int lat, se_err;
    mux_mode = 0;
    pat = 16'hA5C3;
    start_and_wait(lat, se_err);
    n_checks++; if (lat !== 160) begin n_fail++; $display("FAIL clean_latency: got %0d want 160", lat); end
    n_checks++; if (se_err !== 0) begin n_fail++; $display("FAIL clean_se_track: got %0d bad cycles want 0", se_err); end
    n_checks++; if (resp !== 16'hA5C3) begin n_fail++; $display("FAIL clean_resp: got %h want a5c3", resp); end
    n_checks++; if (resp_stable !== 16'hFFFF) begin n_fail++; $display("FAIL clean_stable: got %h want ffff", resp_stable); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL clean_busy_done: got %b want 1", busy); end
    ack();
    n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL clean_valid_drop: got %b want 0", resp_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL clean_busy_idle: got %b want 0", busy); end
    n_checks++; if (resp !== 16'hA5C3) begin n_fail++; $display("FAIL clean_resp_kept: got %h want a5c3", resp); end
  endtask

  task automatic test_noisy_vote();
    int lat, se_err;
    logic [15:0] er, es;
    mux_mode = 1;
    for (int c = 0; c < 16; c++) smp_tbl[c] = 16'h0;
    smp_tbl[3] = 16'h000B;  // 1,1,0,1,0
    smp_tbl[5] = 16'h0012;  // 0,1,0,0,1
    model_scan(er, es);
    start_and_wait(lat, se_err);
    n_checks++; if (lat !== 160) begin n_fail++; $display("FAIL noisy_latency: got %0d want 160", lat); end
    n_checks++; if (resp !== er) begin n_fail++; $display("FAIL noisy_resp: got %h want %h", resp, er); end
    n_checks++; if (resp_stable !== es) begin n_fail++; $display("FAIL noisy_stable: got %h want %h", resp_stable, es); end
    ack();
  endtask

  task automatic test_random_scans();
    int lat, se_err;
    logic [15:0] er, es;
    mux_mode = 1;
    for (int it = 0; it < 3; it++) begin
      rand_tbl();
      model_scan(er, es);
      start_and_wait(lat, se_err);
      n_checks++; if (lat !== 160) begin n_fail++; $display("FAIL rand_latency[%0d]: got %0d want 160", it, lat); end
      n_checks++; if (resp !== er) begin n_fail++; $display("FAIL rand_resp[%0d]: got %h want %h", it, resp, er); end
      n_checks++; if (resp_stable !== es) begin n_fail++; $display("FAIL rand_stable[%0d]: got %h want %h", it, resp_stable, es); end
      ack();
    end
  endtask

  task automatic test_backpressure();
    int lat, se_err, errs;
    logic [15:0] er, es;
    mux_mode = 1;
    rand_tbl();
    model_scan(er, es);
    start_and_wait(lat, se_err);
    n_checks++; if (lat !== 160) begin n_fail++; $display("FAIL bp_latency: got %0d want 160", lat); end
    errs = 0;
    for (int i = 0; i < 20; i++) begin
      start = (i == 5 || i == 12);
      @(negedge clk);
      if (resp_valid !== 1'b1 || busy !== 1'b1 || resp !== er || resp_stable !== es) errs++;
    end
    start = 1'b0;
    n_checks++; if (errs !== 0) begin n_fail++; $display("FAIL bp_hold: got %0d bad cycles want 0", errs); end
    start = 1'b1;
    resp_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    resp_ready = 1'b0;
    n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_valid_drop: got %b want 0", resp_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_start_ignored: got busy %b want 0", busy); end
    n_checks++; if (resp !== er) begin n_fail++; $display("FAIL bp_resp_kept: got %h want %h", resp, er); end
  endtask

  task automatic test_abort();
    int lat, se_err, errs;
    logic [15:0] er, es;
    mux_mode = 1;
    rand_tbl();
    start = 1'b1;
    kedge = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    repeat (76) @(negedge clk);
    n_checks++; if (se !== 4'd7) begin n_fail++; $display("FAIL abort_pre_se: got %h want 7", se); end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_checks++; if (se !== 4'h0) begin n_fail++; $display("FAIL abort_se: got %h want 0", se); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy); end
    n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL abort_valid: got %b want 0", resp_valid); end
    errs = 0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (resp_valid !== 1'b0 || busy !== 1'b0) errs++;
    end
    n_checks++; if (errs !== 0) begin n_fail++; $display("FAIL abort_quiet: got %0d bad cycles want 0", errs); end
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_beats_start: got busy %b want 0", busy); end
    rand_tbl();
    model_scan(er, es);
    start_and_wait(lat, se_err);
    n_checks++; if (lat !== 160) begin n_fail++; $display("FAIL abort_rescan_latency: got %0d want 160", lat); end
    n_checks++; if (se_err !== 0) begin n_fail++; $display("FAIL abort_rescan_se: got %0d bad cycles want 0", se_err); end
    n_checks++; if (resp !== er) begin n_fail++; $display("FAIL abort_rescan_resp: got %h want %h", resp, er); end
    n_checks++; if (resp_stable !== es) begin n_fail++; $display("FAIL abort_rescan_stable: got %h want %h", resp_stable, es); end
    ack();
  endtask

  task automatic test_param_sweep();
    int lat;
    for (int it = 0; it < 2; it++) begin
      pat2 = (it == 0) ? 16'h3C69 : 16'($urandom);
      start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      lat = -1;
      for (int d = 0; d < 200; d++) begin
        if (valid2 === 1'b1) begin
          lat = d;
          break;
        end
        @(negedge clk);
      end
      n_checks++; if (lat !== 48) begin n_fail++; $display("FAIL sweep_latency[%0d]: got %0d want 48", it, lat); end
      n_checks++; if (resp2 !== pat2) begin n_fail++; $display("FAIL sweep_resp[%0d]: got %h want %h", it, resp2, pat2); end
      n_checks++; if (stable2 !== 16'hFFFF) begin n_fail++; $display("FAIL sweep_stable[%0d]: got %h want ffff", it, stable2); end
      ready2 = 1'b1;
      @(negedge clk);
      ready2 = 1'b0;
      n_checks++; if (valid2 !== 1'b0 || busy2 !== 1'b0) begin n_fail++; $display("FAIL sweep_ack[%0d]: got valid %b busy %b want 0 0", it, valid2, busy2); end
    end
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    abort      = 1'b0;
    resp_ready = 1'b0;
    start2     = 1'b0;
    ready2     = 1'b0;
    test_reset();
    test_clean_scan();
    test_noisy_vote();
    test_random_scans();
    test_backpressure();
    test_abort();
    test_param_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/puf_resp_scanner.md
Name: puf_resp_scanner

Overview:
Sequencer that drives the 4-bit select of the 16:1 response multiplexer on the arbiter PUF path. It sweeps all 16 channels and waits a settle interval after each select change. Each channel's mux output is sampled several times and majority-voted, building a 16-bit response word and a per-bit stability mask. The result is handed to the downstream readout/UART logic over a valid/ready handshake.

Parameters:
SETTLE_CYCLES, 4, cycles se is held stable before sampling starts (>=1, <=255)
SAMPLES, 5, samples taken per channel for majority vote (odd, 1..15)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
start  input  1  begin a 16-channel scan; honoured only in IDLE
abort  input  1  cancel the scan in progress; return to IDLE
mux_out  input  1  output of the 16:1 response mux
se  output  4  registered mux select (current channel index)
busy  output  1  high in every state except IDLE
resp  output  16  majority-voted response; bit c = channel c
resp_stable  output  16  bit c high if all SAMPLES of channel c agreed
resp_valid  output  1  resp/resp_stable valid; held until accepted
resp_ready  input  1  downstream accepts result when high with resp_valid

Behaviour:
- Reset (synchronous, active-high): state IDLE, se=0, busy=0, resp=0, resp_stable=0, resp_valid=0, channel and sample counters cleared. Reset overrides all other inputs, including mid-scan.
- States: IDLE, SETTLE, SAMPLE, VOTE, DONE.
- IDLE: start=1 at edge k moves to SETTLE and clears resp, resp_stable and the channel index to 0. Cycle k+1 is the first SETTLE cycle.
- SETTLE: lasts exactly SETTLE_CYCLES cycles. se equals the channel index. mux_out is ignored.
- SAMPLE: lasts exactly SAMPLES cycles. mux_out is registered on every edge into a ones-counter (4 bits).
- VOTE: lasts 1 cycle.
  - resp[ch] = (ones > SAMPLES/2).
  - resp_stable[ch] = (ones==0 || ones==SAMPLES).
  - ones counter is cleared.
  - If ch==15, go to DONE. Otherwise ch+1 and go to SETTLE; se updates on the same edge.
- Per-channel cost is SETTLE_CYCLES+SAMPLES+1 cycles. With defaults that is 10 cycles, and resp_valid first goes high in cycle k+161 (k+1+16*(S+N+1) in general).
- DONE: resp_valid=1. resp and resp_stable are frozen. On resp_valid && resp_ready, return to IDLE; resp_valid drops the next cycle. resp keeps its value in IDLE until the next start.
- start is ignored in every state except IDLE, including DONE when asserted in the same cycle as resp_ready.
- se changes only on SETTLE entry. It is constant across each channel's SETTLE+SAMPLE+VOTE window. No wrap past 15 (channel counter saturates; DONE follows ch 15).
- abort=1 in SETTLE/SAMPLE/VOTE/DONE: next state is IDLE, se=0, resp_valid=0, busy=0. Partially filled resp is left as-is but never flagged valid. abort has priority over start and resp_ready. abort in IDLE has no effect.
- Simultaneous start and abort in IDLE: abort wins, state stays IDLE.
- busy is a registered decode of state: 0 in IDLE, 1 elsewhere (including DONE).

Decomposition:
- Package puf_scan_pkg holds:
  - NUM_CH=16 and SEL_W=4 constants.
  - scan_state_t enum {IDLE, SETTLE, SAMPLE, VOTE, DONE}.
  - Counter width constants (SET_CNT_W=8, SMP_CNT_W=4).
- One natural sub-module: puf_maj_vote (ones-counter plus threshold/stability compare, parameterised by SAMPLES). Its outputs are resp bit and stable bit for the current channel; the FSM writes them at VOTE.

Test Plan:
- Reset check: assert reset 3 cycles mid-scan (channel 6) -> next cycle se=0, busy=0, resp=0, resp_stable=0, resp_valid=0; state IDLE.
- Clean scan: behavioural mux model returns bit se of 16'hA5C3; start at cycle k -> resp_valid rises at k+161, resp=16'hA5C3, resp_stable=16'hFFFF. se equals c during cycles k+1+10c..k+10+10c.
- Noisy vote:
  - Channel 3 samples 1,1,0,1,0 -> resp[3]=1, resp_stable[3]=0.
  - Channel 5 samples 0,1,0,0,1 -> resp[5]=0, resp_stable[5]=0.
  - All other channels are constant 0 -> resp=16'h0008, resp_stable=16'hFFD7.
- Backpressure: hold resp_ready=0 for 20 cycles after resp_valid and pulse start twice -> resp_valid stays 1 and resp stays unchanged, starts ignored. resp_ready=1 -> next cycle resp_valid=0, busy=0.
- Abort: abort during SAMPLE of channel 7 -> next cycle IDLE, se=0, busy=0, resp_valid never asserted. Fresh start then completes a full 161-cycle scan with the correct resp.
- Parameter sweep: SETTLE_CYCLES=1, SAMPLES=1 -> resp_valid at k+49, resp equals the mux pattern, resp_stable=16'hFFFF.
